// File: rtl/audio_psg.sv
// rtl/audio_psg.sv - 8-voice programmable sound generator with stereo 8-bit PWM outputs
//
// Purpose:
//    Eight time-multiplexed voices (pulse / saw / triangle / noise) share one
//    arithmetic path. Each 256-clock sample period is divided as follows:
//      - Voice v is evaluated at cnt = v (0..7).
//      - Its signed, volume-scaled sample is accumulated into the left and/or
//        right mix.
//      - At cnt = 255 each mix is converted to an 8-bit PWM duty for the next
//        period, and the mix is cleared.
//
// Ports:
//    clk         in   1  system clock, rising-edge logic
//    rst         in   1  asynchronous active-low reset
//    ram_wraddr  in   5  register address: voice = [4:2], byte = [1:0]
//    ram_wrdata  in   8  register write data
//    ram_write   in   1  write strobe, sampled on rising clk
//    audio_l     out  1  left PWM output
//    audio_r     out  1  right PWM output
//
// Register bytes per voice:
//    b0 freq[7:0]
//    b1 freq[15:8]
//    b2 {R_en, L_en, vol[5:0]}
//    b3 {wave[1:0], pw[5:0]}

module audio_psg (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] ram_wraddr,
   input  logic [7:0] ram_wrdata,
   input  logic       ram_write,
   output logic       audio_l,
   output logic       audio_r
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [7:0]         regs_q [32];
   logic [7:0]         cnt_q, cnt_d;
   logic [16:0]        phase_q [8];
   logic [16:0]        phase_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic signed [14:0] mix_l_q, mix_l_d;
   logic signed [14:0] mix_r_q, mix_r_d;
   logic [7:0]         duty_l_q, duty_l_d;
   logic [7:0]         duty_r_q, duty_r_d;
   logic               audio_l_q, audio_l_d;
   logic               audio_r_q, audio_r_d;

   // ------------------------------------------------------------------
   // Voice datapath signals
   // ------------------------------------------------------------------
   logic [2:0]         vsel;
   logic               slot_active;
   logic [15:0]        freq;
   logic [7:0]         ctl;
   logic [7:0]         wctl;
   logic [5:0]         pos;
   logic [5:0]         tri_v;
   logic [5:0]         noise_w;
   logic [5:0]         wval;
   logic [15:0]        lfsr_step;
   logic signed [6:0]  samp;
   logic signed [12:0] samp_x;
   logic signed [12:0] vol_x;
   logic signed [12:0] contrib;
   logic signed [14:0] contrib_x;

   // ------------------------------------------------------------------
   // Host register file (write-only from the bus side)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 8'd0;
         end
      end else if (ram_write) begin
         regs_q[ram_wraddr] <= ram_wrdata;
      end
   end

   // ------------------------------------------------------------------
   // Shared voice datapath: evaluates the voice selected by cnt[2:0]
   // ------------------------------------------------------------------
   always_comb begin
      vsel        = cnt_q[2:0];
      slot_active = (cnt_q[7:3] == 5'd0);

      freq = {regs_q[{vsel, 2'd1}], regs_q[{vsel, 2'd0}]};
      ctl  = regs_q[{vsel, 2'd2}];
      wctl = regs_q[{vsel, 2'd3}];

      // 17-bit phase accumulator wraps naturally.
      phase_d = phase_q[vsel] + {1'b0, freq};
      pos     = phase_d[16:11];
      tri_v   = phase_d[16] ? ~phase_d[15:10] : phase_d[15:10];

      // Taps 16,14,13,11 -> bits 15,13,12,10, shifted in at the bottom.
      lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      // The LFSR advances on the cnt = 0 edge. Voice 0 is evaluated on that
      // same edge, so it is handed the stepped value; this way every voice in
      // a period hears the same noise word.
      noise_w = (cnt_q == 8'd0) ? lfsr_step[5:0] : lfsr_q[5:0];

      case (wctl[7:6])
         2'd0:    wval = (pos < wctl[5:0]) ? 6'd63 : 6'd0;
         2'd1:    wval = pos;
         2'd2:    wval = tri_v;
         default: wval = noise_w;
      endcase

      // Signed sample -32..31 scaled by an unsigned 6-bit volume.
      samp      = $signed({1'b0, wval}) - 7'sd32;
      samp_x    = {{6{samp[6]}}, samp};
      vol_x     = $signed({7'd0, ctl[5:0]});
      contrib   = samp_x * vol_x;
      contrib_x = {{2{contrib[12]}}, contrib};
   end

   // ------------------------------------------------------------------
   // Sequencer, mixer, duty latch and PWM comparator
   // ------------------------------------------------------------------
   always_comb begin
      cnt_d    = cnt_q + 8'd1;
      lfsr_d   = (cnt_q == 8'd0) ? lfsr_step : lfsr_q;
      mix_l_d  = mix_l_q;
      mix_r_d  = mix_r_q;
      duty_l_d = duty_l_q;
      duty_r_d = duty_r_q;

      if (slot_active) begin
         if (ctl[6]) begin
            mix_l_d = mix_l_q + contrib_x;
         end
         if (ctl[7]) begin
            mix_r_d = mix_r_q + contrib_x;
         end
      end

      // End of period: top 8 bits of the mix in offset binary become the
      // duty for the whole next period; the mix restarts from zero.
      if (cnt_q == 8'hFF) begin
         duty_l_d = {~mix_l_q[14], mix_l_q[13:7]};
         duty_r_d = {~mix_r_q[14], mix_r_q[13:7]};
         mix_l_d  = 15'sd0;
         mix_r_d  = 15'sd0;
      end

      audio_l_d = (cnt_q < duty_l_q);
      audio_r_d = (cnt_q < duty_r_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= 8'd0;
         lfsr_q    <= 16'h0001;
         mix_l_q   <= 15'sd0;
         mix_r_q   <= 15'sd0;
         duty_l_q  <= 8'h80;
         duty_r_q  <= 8'h80;
         audio_l_q <= 1'b0;
         audio_r_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         lfsr_q    <= lfsr_d;
         mix_l_q   <= mix_l_d;
         mix_r_q   <= mix_r_d;
         duty_l_q  <= duty_l_d;
         duty_r_q  <= duty_r_d;
         audio_l_q <= audio_l_d;
         audio_r_q <= audio_r_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            phase_q[i] <= 17'd0;
         end
      end else if (slot_active) begin
         phase_q[vsel] <= phase_d;
      end
   end

   assign audio_l = audio_l_q;
   assign audio_r = audio_r_q;

endmodule

// File: tb/tb_audio_psg.sv
// tb/tb_audio_psg.sv - testbench for audio_psg

module tb_audio_psg;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] ram_wraddr = 5'd0;
   logic [7:0] ram_wrdata = 8'd0;
   logic       ram_write = 1'b0;
   logic       audio_l;
   logic       audio_r;

   always #5 clk = ~clk;

   audio_psg dut (
      .clk        (clk),
      .rst        (rst),
      .ram_wraddr (ram_wraddr),
      .ram_wrdata (ram_wrdata),
      .ram_write  (ram_write),
      .audio_l    (audio_l),
      .audio_r    (audio_r)
   );

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   // Reference model state (per-period abstraction)
   int mreg   [32];
   int mphase [8];
   int mlfsr;
   int mduty_l;
   int mduty_r;

   typedef struct {
      int slot;
      int addr;
      int data;
   } wr_t;
   wr_t sched[$];

   int meas_l;
   int meas_r;
   bit used [256];
   int slot;
   int nwr;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mreg[i] = 0;
      for (int v = 0; v < 8; v++) mphase[v] = 0;
      mlfsr   = 1;
      mduty_l = 128;
      mduty_r = 128;
      sched.delete();
   endtask

   task automatic add_wr(input int s, input int a, input int d);
      wr_t w;
      w.slot = s;
      w.addr = a;
      w.data = d;
      sched.push_back(w);
   endtask

   // One sample period of the spec's arithmetic; yields the next period's duty.
   task automatic model_period();
      int mix_l = 0;
      int mix_r = 0;
      int fb, freq, ctl, wv, p, t, w, contrib;
      fb    = ((mlfsr >> 15) ^ (mlfsr >> 13) ^ (mlfsr >> 12) ^ (mlfsr >> 10)) & 1;
      mlfsr = ((mlfsr << 1) | fb) & 'hFFFF;
      for (int v = 0; v < 8; v++) begin
         // writes that landed before this voice's slot are already visible
         foreach (sched[i]) begin
            if (sched[i].addr / 4 == v && sched[i].slot < v) mreg[sched[i].addr] = sched[i].data;
         end
         freq      = mreg[4*v] + 256 * mreg[4*v+1];
         ctl       = mreg[4*v+2];
         wv        = mreg[4*v+3];
         mphase[v] = (mphase[v] + freq) % 131072;
         p         = mphase[v] / 2048;
         case (wv / 64)
            0: w = (p < wv % 64) ? 63 : 0;
            1: w = p;
            2: begin
               t = (mphase[v] / 1024) % 64;
               w = (mphase[v] >= 65536) ? 63 - t : t;
            end
            default: w = mlfsr % 64;
         endcase
         contrib = (w - 32) * (ctl % 64);
         if ((ctl & 64) != 0)  mix_l += contrib;
         if ((ctl & 128) != 0) mix_r += contrib;
      end
      foreach (sched[i]) begin
         if (!(sched[i].slot < sched[i].addr / 4)) mreg[sched[i].addr] = sched[i].data;
      end
      mduty_l = (mix_l >>> 7) + 128;
      mduty_r = (mix_r >>> 7) + 128;
   endtask

   // Runs one full 256-clock period starting at cnt = 0, issuing scheduled
   // writes and counting high samples on each output.
   task automatic run_period(input string tag);
      meas_l = 0;
      meas_r = 0;
      for (int c = 0; c < 256; c++) begin
         ram_write = 1'b0;
         foreach (sched[i]) begin
            if (sched[i].slot == c) begin
               ram_write  = 1'b1;
               ram_wraddr = 5'(sched[i].addr);
               ram_wrdata = 8'(sched[i].data);
            end
         end
         @(posedge clk);
         @(negedge clk);
         meas_l += int'(audio_l);
         meas_r += int'(audio_r);
      end
      ram_write = 1'b0;
      check({tag, "_l"}, meas_l, mduty_l);
      check({tag, "_r"}, meas_r, mduty_r);
      model_period();
      sched.delete();
   endtask

   task automatic write_voice(input int v, input int b0, input int b1, input int b2,
                              input int b3, input int base);
      add_wr(base,     4*v,     b0);
      add_wr(base + 1, 4*v + 1, b1);
      add_wr(base + 2, 4*v + 2, b2);
      add_wr(base + 3, 4*v + 3, b3);
   endtask

   initial begin
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_l", int'(audio_l), 0);
      check("reset_r", int'(audio_r), 0);
      rst = 1'b1;

      // Idle: 128/256 both sides
      run_period("idle0");
      run_period("idle1");
      check("idle_const_l", meas_l, 128);

      // V0 pulse pw63 vol63 L+R -> 143
      write_voice(0, 'h00, 'h00, 'hFF, 'h3F, 20);
      run_period("v0p_wr");
      run_period("v0p_a");
      run_period("v0p_b");
      check("v0_pulse_l", meas_l, 143);
      check("v0_pulse_r", meas_r, 143);

      // V0 L only, pw0 -> 112 / 128
      write_voice(0, 'h00, 'h00, 'h7F, 'h00, 40);
      run_period("v0l_wr");
      run_period("v0l_a");
      run_period("v0l_b");
      check("v0_lonly_l", meas_l, 112);
      check("v0_lonly_r", meas_r, 128);

      // All eight voices -> 250, then volume 0 -> 128
      for (int v = 0; v < 8; v++) write_voice(v, 'h00, 'h00, 'hFF, 'h3F, 16 + 4*v);
      run_period("all_wr");
      run_period("all_a");
      run_period("all_b");
      check("all_max_l", meas_l, 250);
      check("all_max_r", meas_r, 250);
      for (int v = 0; v < 8; v++) add_wr(60 + v, 4*v + 2, 'hC0);
      run_period("vol0_wr");
      run_period("vol0_a");
      run_period("vol0_b");
      check("vol0_l", meas_l, 128);

      // Saw on V0, freq 0x0F00: ramp checked against the model
      write_voice(0, 'h00, 'h0F, 'hFF, 'h40, 80);
      for (int n = 0; n < 40; n++) run_period("saw");

      // Writes during the voice slots: V2/V7 land before their slots, V1 after
      add_wr(100, 2, 'h00);
      run_period("slot_prep");
      run_period("slot_prep2");
      add_wr(1, 4*2 + 2, 'hFF);
      add_wr(2, 4*1 + 2, 'hFF);
      add_wr(3, 4*7 + 2, 'hFF);
      run_period("slot_b");
      run_period("slot_c");
      check("slot_early_l", meas_l, 158);
      run_period("slot_d");
      check("slot_late_l", meas_l, 173);

      // Randomized register traffic, including the voice-slot window
      for (int n = 0; n < 12; n++) begin
         foreach (used[i]) used[i] = 1'b0;
         nwr = $urandom_range(0, 6);
         for (int j = 0; j < nwr; j++) begin
            slot = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 9) : $urandom_range(0, 255);
            while (used[slot]) slot = (slot + 1) % 256;
            used[slot] = 1'b1;
            add_wr(slot, $urandom_range(0, 31), $urandom_range(0, 255));
         end
         run_period("rand");
      end

      // Mid-period reset with V0 driving 143
      for (int a = 0; a < 32; a++) add_wr(20 + a, a, 0);
      write_voice(0, 'h00, 'h00, 'hFF, 'h3F, 60);
      run_period("pre_wr");
      run_period("pre_a");
      run_period("pre_b");
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("pre_rst_l", int'(audio_l), 1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_l", int'(audio_l), 0);
      check("async_rst_r", int'(audio_r), 0);
      repeat (3) @(negedge clk);
      check("hold_rst_l", int'(audio_l), 0);
      rst = 1'b1;
      model_reset();
      run_period("post_rst0");
      run_period("post_rst1");
      check("post_rst_l", meas_l, 128);
      check("post_rst_r", meas_r, 128);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
